spi_reg_ctrl: RTL and testbench

Register-access controller between the SPI byte engine (`spi_device`) and a small on-chip register file. It decodes framed byte streams from the host into single-byte or burst register reads and writes. It keeps the SPI reply byte primed ahead of every host byte, and it exposes register 0 as the design's `state` for the LEDs. It replaces the simple mirror store in `top`.

---
 rtl/comm_pkg.sv | 21 ++
 rtl/reg_bank.sv | 34 +++
 rtl/spi_reg_ctrl.sv | 131 +++++++++++++
 tb/tb_spi_reg_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/comm_pkg.sv
// Shared types and constants for the SPI register-access controller.
package comm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_WR   = 3'd2,
    ST_RD   = 3'd3,
    ST_SKIP = 3'd4
  } ctrl_state_e;

  localparam int         RW_BIT    = 7;
  localparam logic [7:0] FILL_ZERO = 8'h00;
  localparam logic [7:0] FILL_ONE  = 8'hFF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) return v;
    else            return v + 8'h01;
  endfunction

endpackage

// File: rtl/reg_bank.sv
// NREG x 8 register array: one write port, one combinational read port,
// top slot is a read-only view of an external byte.
module reg_bank #(
  parameter int NREG = 16,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  input  logic [7:0]    ro_data,
  output logic [7:0]    rdata,
  output logic [7:0]    reg0
);

  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

  logic [7:0] regs_r [NREG];

  // Register storage; writes to the read-only slot are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_r[i] <= 8'h00;
    end else if (we && (waddr != LAST)) begin
      regs_r[waddr] <= wdata;
    end
  end

  assign rdata = (raddr == LAST) ? ro_data : regs_r[raddr];
  assign reg0  = regs_r[0];

endmodule

// File: rtl/spi_reg_ctrl.sv
// Decodes framed SPI bytes into single/burst register reads and writes,
// keeping the reply byte primed ahead of each host byte.
module spi_reg_ctrl
  import comm_pkg::*;
#(
  parameter int         NREG = 16,
  parameter logic [7:0] ID   = 8'h5A
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ssn,
  input  logic       recv_ready,
  output logic       recv_ack,
  input  logic [7:0] cmd,
  output logic       sent_ready,
  input  logic       sent_ack,
  output logic [7:0] reply,
  output logic [7:0] state,
  output logic [7:0] err_cnt
);

  localparam int         AW     = $clog2(NREG);
  localparam logic [7:0] NREG_B = 8'(NREG);

  ctrl_state_e   state_r;
  logic [AW-1:0] ptr_r;
  logic [7:0]    reply_r;
  logic          sent_ready_r;
  logic          recv_ack_r;
  logic [7:0]    err_cnt_r;

  logic          consume_s;
  logic          bad_cmd_s;
  logic          we_s;
  logic [AW-1:0] ptr_inc_s;
  logic [AW-1:0] raddr_s;
  logic [7:0]    rdata_s;

  assign consume_s = recv_ready & ~recv_ack_r;
  assign bad_cmd_s = ({1'b0, cmd[6:0]} >= NREG_B);
  assign ptr_inc_s = ptr_r + AW'(1);
  // An aborting ssn beats a byte arriving on the same edge.
  assign we_s      = consume_s & ~ssn & (state_r == ST_WR);

  // Read port address: the command's addr in CMD, otherwise the next burst slot.
  always_comb begin
    raddr_s = ptr_inc_s;
    if (state_r == ST_CMD) raddr_s = cmd[AW-1:0];
    else                   raddr_s = ptr_inc_s;
  end

  reg_bank #(.NREG(NREG), .AW(AW)) u_bank (
    .clk     (clk),
    .reset   (reset),
    .we      (we_s),
    .waddr   (ptr_r),
    .wdata   (cmd),
    .raddr   (raddr_s),
    .ro_data (err_cnt_r),
    .rdata   (rdata_s),
    .reg0    (state)
  );

  // Controller FSM with receive/send handshakes and the error counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      ptr_r        <= '0;
      reply_r      <= 8'h00;
      sent_ready_r <= 1'b0;
      recv_ack_r   <= 1'b0;
      err_cnt_r    <= 8'h00;
    end else begin
      if (consume_s)                     recv_ack_r <= 1'b1;
      else if (recv_ack_r && !recv_ready) recv_ack_r <= 1'b0;

      if (sent_ready_r && sent_ack) sent_ready_r <= 1'b0;

      if (state_r == ST_IDLE) begin
        if (!ssn) begin
          reply_r      <= ID;
          sent_ready_r <= 1'b1;
          state_r      <= ST_CMD;
        end
      end else if (ssn) begin
        sent_ready_r <= 1'b0;
        state_r      <= ST_IDLE;
      end else if (consume_s) begin
        // Every consumed byte re-primes the reply, superseding any un-acked one.
        sent_ready_r <= 1'b1;
        case (state_r)
          ST_CMD: begin
            if (bad_cmd_s) begin
              err_cnt_r <= sat_inc8(err_cnt_r);
              reply_r   <= FILL_ONE;
              state_r   <= ST_SKIP;
            end else begin
              ptr_r <= cmd[AW-1:0];
              if (cmd[RW_BIT]) begin
                reply_r <= FILL_ZERO;
                state_r <= ST_WR;
              end else begin
                reply_r <= rdata_s;
                state_r <= ST_RD;
              end
            end
          end
          ST_WR: begin
            ptr_r   <= ptr_inc_s;
            reply_r <= FILL_ZERO;
          end
          ST_RD: begin
            ptr_r   <= ptr_inc_s;
            reply_r <= rdata_s;
          end
          ST_SKIP: reply_r <= FILL_ONE;
          default: begin
            sent_ready_r <= 1'b0;
            state_r      <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign recv_ack   = recv_ack_r;
  assign sent_ready = sent_ready_r;
  assign reply      = reply_r;
  assign err_cnt    = err_cnt_r;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl acting as the spi_device byte engine.
module tb_spi_reg_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ssn = 1'b1;
  logic       recv_ready = 1'b0;
  logic       recv_ack;
  logic [7:0] cmd = 8'h00;
  logic       sent_ready;
  logic       sent_ack = 1'b0;
  logic [7:0] reply;
  logic [7:0] state;
  logic [7:0] err_cnt;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  logic [7:0] tx_q [8];
  logic [7:0] rx_q [9];

  spi_reg_ctrl #(.NREG(16), .ID(8'h5A)) dut (
    .clk        (clk),
    .reset      (reset),
    .ssn        (ssn),
    .recv_ready (recv_ready),
    .recv_ack   (recv_ack),
    .cmd        (cmd),
    .sent_ready (sent_ready),
    .sent_ack   (sent_ack),
    .reply      (reply),
    .state      (state),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic get_reply(output logic [7:0] r);
    for (int k = 0; k < 20 && !sent_ready; k++) step();
    check_val("sent_ready_wait", {7'h00, sent_ready}, 8'h01);
    r = reply;
    sent_ack = 1'b1;
    step();
    sent_ack = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    cmd = b;
    recv_ready = 1'b1;
    for (int k = 0; k < 20 && !recv_ack; k++) step();
    check_val("recv_ack_rise", {7'h00, recv_ack}, 8'h01);
    recv_ready = 1'b0;
    for (int k = 0; k < 20 && recv_ack; k++) step();
    check_val("recv_ack_fall", {7'h00, recv_ack}, 8'h00);
  endtask

  // Full frame: rx_q[i] is the reply shifted out while tx_q[i] goes in.
  task automatic do_frame(input int n);
    ssn = 1'b0;
    step();
    get_reply(rx_q[0]);
    for (int i = 0; i < n; i++) begin
      send_byte(tx_q[i]);
      get_reply(rx_q[i+1]);
    end
    ssn = 1'b1;
    step(); step(); step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(); step();
    check_val("rst_recv_ack", {7'h00, recv_ack}, 8'h00);
    check_val("rst_sent_ready", {7'h00, sent_ready}, 8'h00);
    check_val("rst_reply", reply, 8'h00);
    check_val("rst_state", state, 8'h00);
    check_val("rst_err_cnt", err_cnt, 8'h00);
    reset = 1'b0;
    step();

    // Single write to reg0
    tx_q[0] = 8'h80; tx_q[1] = 8'h07;
    do_frame(2);
    check_val("w0_id", rx_q[0], 8'h5A);
    check_val("w0_r1", rx_q[1], 8'h00);
    check_val("w0_state", state, 8'h07);

    // Burst write then burst read
    tx_q[0] = 8'h82; tx_q[1] = 8'h11; tx_q[2] = 8'h22; tx_q[3] = 8'h33;
    do_frame(4);
    tx_q[0] = 8'h02; tx_q[1] = 8'h00; tx_q[2] = 8'h00; tx_q[3] = 8'h00;
    do_frame(4);
    check_val("br_id", rx_q[0], 8'h5A);
    check_val("br_r1", rx_q[1], 8'h11);
    check_val("br_r2", rx_q[2], 8'h22);
    check_val("br_r3", rx_q[3], 8'h33);
    check_val("br_r4", rx_q[4], 8'h00);

    // Three bad commands
    tx_q[1] = 8'h00;
    tx_q[0] = 8'h90; do_frame(2);
    check_val("bad1_id", rx_q[0], 8'h5A);
    check_val("bad1_r1", rx_q[1], 8'hFF);
    check_val("bad1_r2", rx_q[2], 8'hFF);
    tx_q[0] = 8'hFF; do_frame(2);
    check_val("bad2_r1", rx_q[1], 8'hFF);
    tx_q[0] = 8'h20; do_frame(2);
    check_val("bad3_r1", rx_q[1], 8'hFF);
    check_val("bad_err_cnt", err_cnt, 8'h03);
    tx_q[0] = 8'h0F; tx_q[1] = 8'h00;
    do_frame(2);
    check_val("rd15", rx_q[1], 8'h03);
    check_val("rd15_wrap", rx_q[2], 8'h07);
    tx_q[0] = 8'h8F; tx_q[1] = 8'h55;
    do_frame(2);
    tx_q[0] = 8'h0F; tx_q[1] = 8'h00;
    do_frame(2);
    check_val("rd15_after_wr", rx_q[1], 8'h03);

    // Burst read wrapping 14 -> 15 -> 0 -> 1
    tx_q[0] = 8'h8E; tx_q[1] = 8'hAB;
    do_frame(2);
    tx_q[0] = 8'h0E; tx_q[1] = 8'h00; tx_q[2] = 8'h00; tx_q[3] = 8'h00;
    do_frame(4);
    check_val("wrap_r1", rx_q[1], 8'hAB);
    check_val("wrap_r2", rx_q[2], 8'h03);
    check_val("wrap_r3", rx_q[3], 8'h07);
    check_val("wrap_r4", rx_q[4], 8'h00);

    // Abort: ssn rises together with a pending byte
    ssn = 1'b0;
    step();
    get_reply(rx_q[0]);
    check_val("ab_id", rx_q[0], 8'h5A);
    send_byte(8'h82);
    get_reply(rx_q[1]);
    send_byte(8'h44);
    check_val("ab_primed", {7'h00, sent_ready}, 8'h01);
    cmd = 8'h99;
    recv_ready = 1'b1;
    ssn = 1'b1;
    step();
    check_val("ab_ack_hi", {7'h00, recv_ack}, 8'h01);
    check_val("ab_sr_drop", {7'h00, sent_ready}, 8'h00);
    recv_ready = 1'b0;
    step();
    check_val("ab_ack_lo", {7'h00, recv_ack}, 8'h00);
    step(); step();
    tx_q[0] = 8'h02; tx_q[1] = 8'h00;
    do_frame(2);
    check_val("ab_next_id", rx_q[0], 8'h5A);
    check_val("ab_kept", rx_q[1], 8'h44);
    check_val("ab_dropped", rx_q[2], 8'h22);

    // Reset in the middle of a burst write
    ssn = 1'b0;
    step();
    get_reply(rx_q[0]);
    send_byte(8'h80);
    get_reply(rx_q[1]);
    send_byte(8'h01);
    get_reply(rx_q[2]);
    send_byte(8'h02);
    check_val("mr_state_pre", state, 8'h01);
    reset = 1'b1;
    ssn = 1'b1;
    step();
    check_val("mr_recv_ack", {7'h00, recv_ack}, 8'h00);
    check_val("mr_sent_ready", {7'h00, sent_ready}, 8'h00);
    check_val("mr_reply", reply, 8'h00);
    check_val("mr_state", state, 8'h00);
    check_val("mr_err_cnt", err_cnt, 8'h00);
    reset = 1'b0;
    step();
    tx_q[0] = 8'h01; tx_q[1] = 8'h00;
    do_frame(2);
    check_val("mr_id", rx_q[0], 8'h5A);
    check_val("mr_reg1", rx_q[1], 8'h00);
    check_val("mr_reg2", rx_q[2], 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
